// File: rtl/ahb_sram_ctrl_p.sv
// AHB-Lite slave fronting NUM_BANKS single-port synchronous SRAM banks.
// Size/alignment/range-checked beats, two-cycle ERROR response, one-wait-state RAW stall.
module ahb_sram_ctrl_p #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned NUM_BANKS = 2
) (
  input  logic                        h_clk,
  input  logic                        h_reset_n,
  input  logic                        hsel,
  input  logic [31:0]                 haddr,
  input  logic                        hwen,
  input  logic [1:0]                  htrans,
  input  logic [2:0]                  hsize,
  input  logic [2:0]                  hburst,
  input  logic [DATA_W-1:0]           hwdata,
  input  logic                        hready_in,
  output logic                        hready_out,
  output logic [1:0]                  hresp,
  output logic [DATA_W-1:0]           hrdata,
  output logic [NUM_BANKS-1:0]        sram_cs,
  output logic                        sram_wen,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W/8-1:0]         sram_be,
  output logic [DATA_W-1:0]           sram_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_rdata
);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned BSH    = $clog2(BE_W);
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespError = 2'b01;

  typedef enum logic [2:0] {StIdle, StWr, StRd, StStall, StErr1, StErr2} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [BANK_W-1:0] pend_bank_q, pend_bank_d;
  logic [BE_W-1:0]   pend_be_q, pend_be_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;

  logic [ADDR_W-1:0] dec_word;
  logic [BANK_W-1:0] dec_bank;
  logic [BE_W-1:0]   dec_be;
  logic              dec_legal, beat_req, beat_valid, decode;
  int unsigned       off, nbytes;

  logic unused_bits;
  assign unused_bits = ^{hburst, htrans[0], haddr};

  assign dec_word   = haddr[BSH +: ADDR_W];
  assign dec_bank   = haddr[BSH+ADDR_W +: BANK_W];
  assign beat_req   = hsel & htrans[1];
  assign beat_valid = beat_req & hready_in;

  always_comb begin
    off       = 32'(haddr[BSH-1:0]);
    nbytes    = 32'd1 << hsize;
    dec_legal = (32'(hsize) <= BSH) && ((off & (nbytes - 32'd1)) == 32'd0) &&
                (32'(dec_bank) < NUM_BANKS);
    for (int unsigned i = 0; i < BE_W; i++) begin
      dec_be[i] = dec_legal && (i >= off) && (i < off + nbytes);
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_bank_d = pend_bank_q;
    pend_be_d   = pend_be_q;
    rd_bank_d   = rd_bank_q;
    hready_out  = 1'b1;
    hresp       = RespOkay;
    hrdata      = '0;
    sram_cs     = '0;
    sram_wen    = 1'b0;
    sram_addr   = '0;
    sram_be     = '0;
    sram_wdata  = '0;
    decode      = 1'b0;

    unique case (state_q)
      StIdle: decode = 1'b1;
      StRd: begin
        decode = 1'b1;
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
          if (rd_bank_q == BANK_W'(k)) hrdata = sram_rdata[k*DATA_W +: DATA_W];
        end
      end
      StWr: begin
        sram_cs    = NUM_BANKS'(1) << pend_bank_q;
        sram_wen   = 1'b1;
        sram_addr  = pend_addr_q;
        sram_be    = pend_be_q;
        sram_wdata = hwdata;
        // Port is busy with the write; capture the read and replay it next cycle.
        if (beat_req && !hwen && dec_legal) begin
          hready_out  = 1'b0;
          pend_addr_d = dec_word;
          pend_bank_d = dec_bank;
          pend_be_d   = dec_be;
          state_d     = StStall;
        end else begin
          decode = 1'b1;
        end
      end
      StStall: begin
        sram_cs   = NUM_BANKS'(1) << pend_bank_q;
        sram_addr = pend_addr_q;
        sram_be   = pend_be_q;
        rd_bank_d = pend_bank_q;
        state_d   = StRd;
      end
      StErr1: begin
        hready_out = 1'b0;
        hresp      = RespError;
        state_d    = StErr2;
      end
      StErr2: begin
        hresp  = RespError;
        decode = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (decode) begin
      state_d = StIdle;
      if (beat_valid) begin
        if (!dec_legal) begin
          state_d = StErr1;
        end else if (hwen) begin
          pend_addr_d = dec_word;
          pend_bank_d = dec_bank;
          pend_be_d   = dec_be;
          state_d     = StWr;
        end else begin
          sram_cs   = NUM_BANKS'(1) << dec_bank;
          sram_addr = dec_word;
          sram_be   = dec_be;
          rd_bank_d = dec_bank;
          state_d   = StRd;
        end
      end
    end
  end

  always_ff @(posedge h_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q     <= StIdle;
      pend_addr_q <= '0;
      pend_bank_q <= '0;
      pend_be_q   <= '0;
      rd_bank_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_bank_q <= pend_bank_d;
      pend_be_q   <= pend_be_d;
      rd_bank_q   <= rd_bank_d;
    end
  end
endmodule

// File: tb/tb_ahb_sram_ctrl_p.sv
// Table-driven bench for ahb_sram_ctrl_p: a 32-bit/2-bank and a 64-bit/3-bank instance,
// each backed by a behavioural SRAM model, plus a hand-written reset-abort sequence.
module tb_ahb_sram_ctrl_p;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] BZ = 2'b01;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] ER = 2'b01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        h_reset_n;
  logic        sel0, sel1, hwen, hready_in;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [63:0] hwdata;

  logic        rdy0, wen0;
  logic [1:0]  resp0, cs0;
  logic [31:0] rd0, wd0;
  logic [12:0] addr0;
  logic [3:0]  be0;
  logic [63:0] srd0;

  logic         rdy1, wen1;
  logic [1:0]   resp1;
  logic [2:0]   cs1;
  logic [63:0]  rd1, wd1;
  logic [12:0]  addr1;
  logic [7:0]   be1;
  logic [191:0] srd1;

  ahb_sram_ctrl_p #(.DATA_W(32), .ADDR_W(13), .NUM_BANKS(2)) u_dut0 (
    .h_clk(clk), .h_reset_n(h_reset_n), .hsel(sel0), .haddr(haddr), .hwen(hwen),
    .htrans(htrans), .hsize(hsize), .hburst(3'b001), .hwdata(hwdata[31:0]),
    .hready_in(hready_in), .hready_out(rdy0), .hresp(resp0), .hrdata(rd0), .sram_cs(cs0),
    .sram_wen(wen0), .sram_addr(addr0), .sram_be(be0), .sram_wdata(wd0), .sram_rdata(srd0)
  );

  ahb_sram_ctrl_p #(.DATA_W(64), .ADDR_W(13), .NUM_BANKS(3)) u_dut1 (
    .h_clk(clk), .h_reset_n(h_reset_n), .hsel(sel1), .haddr(haddr), .hwen(hwen),
    .htrans(htrans), .hsize(hsize), .hburst(3'b001), .hwdata(hwdata),
    .hready_in(hready_in), .hready_out(rdy1), .hresp(resp1), .hrdata(rd1), .sram_cs(cs1),
    .sram_wen(wen1), .sram_addr(addr1), .sram_be(be1), .sram_wdata(wd1), .sram_rdata(srd1)
  );

  logic [31:0] mem0 [2][8192];
  logic [63:0] mem1 [3][8192];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs0[k]) begin
        if (wen0) begin
          for (int b = 0; b < 4; b++) if (be0[b]) mem0[k][addr0][b*8 +: 8] <= wd0[b*8 +: 8];
        end else begin
          srd0[k*32 +: 32] <= mem0[k][addr0];
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (cs1[k]) begin
        if (wen1) begin
          for (int b = 0; b < 8; b++) if (be1[b]) mem1[k][addr1][b*8 +: 8] <= wd1[b*8 +: 8];
        end else begin
          srd1[k*64 +: 64] <= mem1[k][addr1];
        end
      end
    end
  end

  typedef struct {
    logic         d;
    logic         sel;
    logic [1:0]   tr;
    logic         wen;
    logic [2:0]   sz;
    logic [31:0]  addr;
    logic [63:0]  wdata;
    logic         rin;
    logic [155:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Observed vector: {ready, resp, cs, wen, addr, be, wdata, rdata}
  function automatic logic [155:0] obs(input logic d);
    if (d) return {rdy1, resp1, cs1, wen1, addr1, be1, wd1, rd1};
    return {rdy0, resp0, 1'b0, cs0, wen0, addr0, 4'b0, be0, 32'b0, wd0, 32'b0, rd0};
  endfunction

  task automatic check(input string name, input logic [155:0] got, input logic [155:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic add(input logic d, input logic sel, input logic [1:0] tr, input logic wen,
                     input logic [2:0] sz, input logic [31:0] a, input logic [63:0] wd,
                     input logic rin, input logic rdy, input logic [1:0] resp,
                     input logic [2:0] cs, input logic swen, input logic [12:0] sa,
                     input logic [7:0] be, input logic [63:0] swd, input logic [63:0] rd);
    vec_t v;
    v.d = d; v.sel = sel; v.tr = tr; v.wen = wen; v.sz = sz; v.addr = a; v.wdata = wd;
    v.rin = rin;
    v.exp = {rdy, resp, cs, swen, sa, be, swd, rd};
    vecs.push_back(v);
  endtask

  // Idle bus inputs; only ready/resp/rdata expected non-zero.
  task automatic idl(input logic d, input logic [1:0] resp, input logic [63:0] wd,
                     input logic [63:0] rd);
    add(d, 1'b0, 2'b00, 1'b0, 3'd0, 32'h0, wd, 1'b1, 1'b1, resp, 3'd0, 1'b0, 13'h0, 8'h0,
        64'h0, rd);
  endtask

  // Address phase that must produce no SRAM activity this cycle.
  task automatic quiet(input logic d, input logic [1:0] tr, input logic wen, input logic [2:0] sz,
                       input logic [31:0] a, input logic rin);
    add(d, 1'b1, tr, wen, sz, a, 64'h0, rin, 1'b1, OK, 3'd0, 1'b0, 13'h0, 8'h0, 64'h0, 64'h0);
  endtask

  task automatic apply(input vec_t v);
    sel0      = v.sel & ~v.d;
    sel1      = v.sel & v.d;
    htrans    = v.tr;
    hwen      = v.wen;
    hsize     = v.sz;
    haddr     = v.addr;
    hwdata    = v.wdata;
    hready_in = v.rin;
  endtask

  localparam logic [155:0] RstExp = {1'b1, 155'd0};

  initial begin
    h_reset_n = 1'b0;
    sel0 = 1'b0; sel1 = 1'b0; hwen = 1'b0; htrans = 2'b00; hsize = 3'd0;
    haddr = 32'h0; hwdata = 64'h0; hready_in = 1'b1;

    // 32-bit, 2 banks: word = haddr[14:2], bank = haddr[15]
    idl(0, OK, 0, 0);
    quiet(0, NS, 1, 3'd2, 32'h8004, 1);
    add(0, 0, 2'b00, 0, 0, 0, 64'hDEADBEEF, 1,  1, OK, 3'b010, 1, 13'h1, 8'hF, 64'hDEADBEEF, 0);
    idl(0, OK, 0, 0);
    add(0, 1, NS, 0, 3'd2, 32'h8004, 0, 1,  1, OK, 3'b010, 0, 13'h1, 8'hF, 0, 0);
    idl(0, OK, 0, 64'hDEADBEEF);
    quiet(0, NS, 1, 3'd2, 32'h10, 1);
    add(0, 1, NS, 0, 3'd2, 32'h10, 64'hCAFEF00D, 0,  0, OK, 3'b001, 1, 13'h4, 8'hF,
        64'hCAFEF00D, 0);
    add(0, 1, NS, 0, 3'd2, 32'h10, 0, 1,  1, OK, 3'b001, 0, 13'h4, 8'hF, 0, 0);
    idl(0, OK, 0, 64'hCAFEF00D);
    quiet(0, NS, 1, 3'd2, 32'h0, 1);
    add(0, 0, 2'b00, 0, 0, 0, 64'h55667788, 1,  1, OK, 3'b001, 1, 13'h0, 8'hF, 64'h55667788, 0);
    quiet(0, NS, 1, 3'd0, 32'h3, 1);
    add(0, 1, NS, 1, 3'd1, 32'h0, 64'hAB000000, 1,  1, OK, 3'b001, 1, 13'h0, 8'h8,
        64'hAB000000, 0);
    add(0, 1, NS, 0, 3'd2, 32'h0, 64'h00001234, 0,  0, OK, 3'b001, 1, 13'h0, 8'h3,
        64'h00001234, 0);
    add(0, 1, NS, 0, 3'd2, 32'h0, 0, 1,  1, OK, 3'b001, 0, 13'h0, 8'hF, 0, 0);
    idl(0, OK, 0, 64'hAB661234);
    quiet(0, NS, 0, 3'd3, 32'h0, 1);
    add(0, 0, 2'b00, 0, 0, 0, 0, 0,  0, ER, 3'd0, 0, 13'h0, 8'h0, 0, 0);
    idl(0, ER, 0, 0);
    quiet(0, NS, 1, 3'd1, 32'h1, 1);
    add(0, 0, 2'b00, 0, 0, 0, 0, 0,  0, ER, 3'd0, 0, 13'h0, 8'h0, 0, 0);
    add(0, 1, NS, 0, 3'd2, 32'h10010, 0, 1,  1, ER, 3'b001, 0, 13'h4, 8'hF, 0, 0);
    add(0, 1, NS, 0, 3'd2, 32'h8004, 0, 1,  1, OK, 3'b010, 0, 13'h1, 8'hF, 0, 64'hCAFEF00D);
    idl(0, OK, 0, 64'hDEADBEEF);
    quiet(0, BZ, 0, 3'd2, 32'h0, 1);
    quiet(0, NS, 0, 3'd2, 32'h0, 0);
    idl(0, OK, 0, 0);
    add(0, 1, NS, 0, 3'd0, 32'h2, 0, 1,  1, OK, 3'b001, 0, 13'h0, 8'h4, 0, 0);
    idl(0, OK, 0, 64'hAB661234);

    // 64-bit, 3 banks: word = haddr[15:3], bank = haddr[17:16]
    idl(1, OK, 0, 0);
    quiet(1, NS, 1, 3'd3, 32'h2FFF8, 1);
    add(1, 0, 2'b00, 0, 0, 0, 64'h0123456789ABCDEF, 1,  1, OK, 3'b100, 1, 13'h1FFF, 8'hFF,
        64'h0123456789ABCDEF, 0);
    idl(1, OK, 0, 0);
    add(1, 1, NS, 0, 3'd3, 32'h2FFF8, 0, 1,  1, OK, 3'b100, 0, 13'h1FFF, 8'hFF, 0, 0);
    idl(1, OK, 0, 64'h0123456789ABCDEF);
    quiet(1, NS, 0, 3'd3, 32'h30000, 1);
    add(1, 0, 2'b00, 0, 0, 0, 0, 0,  0, ER, 3'd0, 0, 13'h0, 8'h0, 0, 0);
    idl(1, ER, 0, 0);
    quiet(1, NS, 1, 3'd2, 32'h4, 1);
    add(1, 0, 2'b00, 0, 0, 0, 64'hAABBCCDD00000000, 1,  1, OK, 3'b001, 1, 13'h0, 8'hF0,
        64'hAABBCCDD00000000, 0);
    idl(1, OK, 0, 0);

    #12;
    check("reset_state", obs(0), RstExp);
    @(posedge clk); #1;
    h_reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      #4;
      check($sformatf("row%0d", i), obs(vecs[i].d), vecs[i].exp);
      @(posedge clk); #1;
    end

    // Reset asserted in the middle of a write data phase.
    sel0 = 1'b1; htrans = NS; hwen = 1'b1; hsize = 3'd2; haddr = 32'h8004; hready_in = 1'b1;
    @(posedge clk); #1;
    sel0 = 1'b0; htrans = 2'b00; hwen = 1'b0; hwdata = 64'h12345678;
    #1;
    check("rst_wr_pending", 156'({cs0, wen0}), 156'({2'b10, 1'b1}));
    h_reset_n = 1'b0;
    #1;
    check("rst_async_outputs", obs(0), RstExp);
    @(posedge clk); #1;
    check("rst_write_dropped", 156'(mem0[1][1]), 156'(32'hDEADBEEF));
    h_reset_n = 1'b1;
    sel0 = 1'b1; htrans = NS; hwen = 1'b0; hsize = 3'd2; haddr = 32'h8004;
    @(posedge clk); #1;
    sel0 = 1'b0; htrans = 2'b00;
    #4;
    check("rst_old_data", obs(0), {1'b1, 2'b0, 3'b0, 1'b0, 13'h0, 8'h0, 64'h0, 64'hDEADBEEF});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
